// File: rtl/dev_uart_rx.sv
// 8N1 serial receiver with 2-flop input synchroniser and mid-bit sampling.
// Each good byte produces a one-cycle data_en strobe; a low stop bit produces a one-cycle frame_err strobe.
module dev_uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_en,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LIM  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LIM = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    data_nxt;
    logic          en_nxt, ferr_nxt;
    logic          sync1, rx_s;

    // Flops reset to 1 so a reset never looks like a start bit on an idle line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            data_out  <= '0;
            data_en   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shift     <= shift_nxt;
            data_out  <= data_nxt;
            data_en   <= en_nxt;
            frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        data_nxt  = data_out;
        en_nxt    = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF_LIM) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LIM) begin
                    cnt_nxt        = '0;
                    shift_nxt[idx] = rx_s;
                    idx_nxt        = idx + 1'b1;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid-stop gives half a bit of slack for a back-to-back start edge.
                if (cnt == BIT_LIM) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        data_nxt  = shift;
                        en_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            BREAK: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dev_uart_rx.sv
// Directed bench for dev_uart_rx: table of single frames on an 8-clock-per-bit instance,
// plus hand sequences for back-to-back, glitch, break, mid-frame reset and baud drift on a 32-clock instance.
module tb_dev_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx8 = 1'b1;
    logic       rx32 = 1'b1;
    logic [7:0] data8, data32;
    logic       en8, en32, ferr8, ferr32, busy8, busy32;

    dev_uart_rx #(.CLKS_PER_BIT(8)) dut8 (
        .clk(clk), .rst(rst), .rx(rx8),
        .data_out(data8), .data_en(en8), .frame_err(ferr8), .busy(busy8)
    );

    dev_uart_rx #(.CLKS_PER_BIT(32)) dut32 (
        .clk(clk), .rst(rst), .rx(rx32),
        .data_out(data32), .data_en(en32), .frame_err(ferr32), .busy(busy32)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cyc = 0;

    // Strobe monitors: counts, timestamps and protocol rule violations per instance.
    int         en_cnt8 = 0, ferr_cnt8 = 0, viol8 = 0, last_cyc8 = 0, prev_cyc8 = 0;
    logic [7:0] last_data8 = 0, prev_data8 = 0, held8 = 0;
    logic       prev_strobe8 = 0;
    int         en_cnt32 = 0, ferr_cnt32 = 0, viol32 = 0;
    logic [7:0] last_data32 = 0, prev_data32 = 0, held32 = 0;
    logic       prev_strobe32 = 0;

    always @(negedge clk) begin
        if (rst) held8 = data8;
        if (en8 && ferr8) viol8++;
        if ((en8 || ferr8) && prev_strobe8) viol8++;
        if (!en8 && !rst && data8 !== held8) viol8++;
        if (en8) begin
            en_cnt8++;
            prev_cyc8  = last_cyc8;
            prev_data8 = last_data8;
            last_cyc8  = cycle;
            last_data8 = data8;
            held8      = data8;
        end
        if (ferr8) ferr_cnt8++;
        prev_strobe8 = en8 || ferr8;

        if (rst) held32 = data32;
        if (en32 && ferr32) viol32++;
        if ((en32 || ferr32) && prev_strobe32) viol32++;
        if (!en32 && !rst && data32 !== held32) viol32++;
        if (en32) begin
            en_cnt32++;
            prev_data32 = last_data32;
            last_data32 = data32;
            held32      = data32;
        end
        if (ferr32) ferr_cnt32++;
        prev_strobe32 = en32 || ferr32;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives a level for a number of cycles; entered and left just after a rising edge.
    task automatic holdLevel(input int which, input logic v, input int cycles);
        if (which == 0) rx8 = v;
        else rx32 = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input logic [7:0] b, input logic stop, input int period);
        start_cyc = cycle;
        holdLevel(which, 1'b0, period);
        for (int i = 0; i < 8; i++) holdLevel(which, b[i], period);
        holdLevel(which, stop, period);
        if (which == 0) rx8 = 1'b1;
        else rx32 = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_en;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int e0, f0, bcnt;
        vecs[0] = '{8'h3E, 1'b1, 1, 8'h3E, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h80, 1'b1, 1, 8'h80, 0};
        vecs[4] = '{8'h01, 1'b1, 1, 8'h01, 0};
        vecs[5] = '{8'h0A, 1'b1, 1, 8'h0A, 0};
        vecs[6] = '{8'h55, 1'b0, 0, 8'h0A, 1};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset data_out", {24'd0, data8}, 32'h0);
        checkOutput("reset data_en", {31'd0, en8}, 32'h0);
        checkOutput("reset frame_err", {31'd0, ferr8}, 32'h0);
        checkOutput("reset busy", {31'd0, busy8}, 32'h0);
        rst = 1'b0;
        bcnt = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (busy8 || busy32) bcnt++;
        end
        checkOutput("idle after reset busy cycles", bcnt, 0);

        for (int i = 0; i < 7; i++) begin
            e0 = en_cnt8;
            f0 = ferr_cnt8;
            applyStimulus(0, vecs[i].data, vecs[i].stop, 8);
            holdLevel(0, 1'b1, 20);
            checkOutput($sformatf("vec%0d data_en count", i), en_cnt8 - e0, vecs[i].exp_en);
            checkOutput($sformatf("vec%0d frame_err count", i), ferr_cnt8 - f0, vecs[i].exp_ferr);
            checkOutput($sformatf("vec%0d data_out", i), {24'd0, data8}, {24'd0, vecs[i].exp_data});
            if (vecs[i].exp_en == 1)
                checkOutput($sformatf("vec%0d latency", i), last_cyc8 - start_cyc, 79);
        end

        // Break: bad stop bit followed by a long low line.
        e0 = en_cnt8;
        f0 = ferr_cnt8;
        applyStimulus(0, 8'h55, 1'b0, 8);
        holdLevel(0, 1'b0, 240);
        holdLevel(0, 1'b1, 20);
        checkOutput("break frame_err count", ferr_cnt8 - f0, 1);
        checkOutput("break data_en count", en_cnt8 - e0, 0);
        checkOutput("break data_out held", {24'd0, data8}, 32'h0A);
        applyStimulus(0, 8'h0A, 1'b1, 8);
        holdLevel(0, 1'b1, 20);
        checkOutput("after break data_en count", en_cnt8 - e0, 1);
        checkOutput("after break data_out", {24'd0, data8}, 32'h0A);

        // Back-to-back "A5".
        e0 = en_cnt8;
        applyStimulus(0, 8'h41, 1'b1, 8);
        applyStimulus(0, 8'h35, 1'b1, 8);
        holdLevel(0, 1'b1, 20);
        checkOutput("b2b data_en count", en_cnt8 - e0, 2);
        checkOutput("b2b spacing", last_cyc8 - prev_cyc8, 80);
        checkOutput("b2b first byte", {24'd0, prev_data8}, 32'h41);
        checkOutput("b2b second byte", {24'd0, last_data8}, 32'h35);
        checkOutput("b2b busy after", {31'd0, busy8}, 32'h0);

        // Two-cycle glitch on an idle line.
        e0 = en_cnt8;
        f0 = ferr_cnt8;
        holdLevel(0, 1'b0, 2);
        rx8 = 1'b1;
        bcnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (busy8) bcnt++;
        end
        checkOutput("glitch busy window", {31'd0, (bcnt >= 1 && bcnt <= 6)}, 32'h1);
        checkOutput("glitch busy after", {31'd0, busy8}, 32'h0);
        checkOutput("glitch data_en count", en_cnt8 - e0, 0);
        checkOutput("glitch frame_err count", ferr_cnt8 - f0, 0);

        // Reset during data bit 3 of 0x7F, then the line goes idle.
        e0 = en_cnt8;
        holdLevel(0, 1'b0, 8);
        holdLevel(0, 1'b1, 28);
        rst = 1'b1;
        #1;
        checkOutput("midframe reset data_out", {24'd0, data8}, 32'h0);
        checkOutput("midframe reset busy", {31'd0, busy8}, 32'h0);
        checkOutput("midframe reset strobes", {30'd0, en8, ferr8}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        holdLevel(0, 1'b1, 120);
        checkOutput("aborted frame data_en count", en_cnt8 - e0, 0);
        applyStimulus(0, 8'h7F, 1'b1, 8);
        holdLevel(0, 1'b1, 20);
        checkOutput("after reset data_en count", en_cnt8 - e0, 1);
        checkOutput("after reset data_out", {24'd0, data8}, 32'h7F);

        // Baud drift on the 32-clock instance: fast then slow transmitter.
        applyStimulus(1, 8'hC3, 1'b1, 31);
        holdLevel(1, 1'b1, 64);
        applyStimulus(1, 8'hC3, 1'b1, 33);
        holdLevel(1, 1'b1, 64);
        checkOutput("drift data_en count", en_cnt32, 2);
        checkOutput("drift frame_err count", ferr_cnt32, 0);
        checkOutput("drift fast byte", {24'd0, prev_data32}, 32'hC3);
        checkOutput("drift slow byte", {24'd0, last_data32}, 32'hC3);
        checkOutput("drift busy after", {31'd0, busy32}, 32'h0);

        checkOutput("strobe rules cpb8", viol8, 0);
        checkOutput("strobe rules cpb32", viol32, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
